// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seg_scan_ctrl : multiplexed 7-segment scan controller with per-slot blanking
// Rev 1.0
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int DIV    = 50000,
   parameter int GUARD  = 500,
   parameter int DIGITS = 8
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iEn,
   input  logic [31:0] iNum,
   input  logic [7:0]  iDp,
   input  logic [7:0]  iBlank,
   output logic [2:0]  oSel,
   output logic [1:0]  oEna,
   output logic [7:0]  oSeg,
   output logic        oFrame
);
   localparam int            CW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] C_CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] C_GUARD    = CW'(GUARD);
   localparam logic [2:0]    C_SEL_LAST = 3'(DIGITS - 1);
   localparam logic [1:0]    C_ENA_ON   = 2'b10;
   localparam logic [1:0]    C_ENA_OFF  = 2'b00;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    sel_q, sel_d;
   logic [1:0]    ena_q, ena_d;
   logic [7:0]    seg_q, seg_d;
   logic          frame_q, frame_d;
   logic          load;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      seg_d   = seg_q;
      ena_d   = C_ENA_OFF;
      frame_d = 1'b0;
      load    = 1'b0;

      if (!iEn) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         sel_d   = 3'd0;
         seg_d   = 8'hFF;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_SCAN;
         cnt_d   = '0;
         sel_d   = 3'd0;
         load    = 1'b1;
      end else if (cnt_q == C_CNT_LAST) begin
         cnt_d   = '0;
         sel_d   = (sel_q == C_SEL_LAST) ? 3'd0 : sel_q + 3'd1;
         frame_d = (sel_q == C_SEL_LAST);
         load    = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      // Digit data is snapshotted only at slot start; mid-slot changes wait a slot.
      if (load) begin
         seg_d = iBlank[sel_d] ? 8'hFF : {~iDp[sel_d], hex7(iNum[{sel_d, 2'b00} +: 4])};
      end

      // Enable is derived from next-cycle state so the guard can never be cut short.
      if (state_d == ST_SCAN && cnt_d >= C_GUARD && !iBlank[sel_d]) begin
         ena_d = C_ENA_ON;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sel_q   <= 3'd0;
         ena_q   <= C_ENA_OFF;
         seg_q   <= 8'hFF;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         ena_q   <= ena_d;
         seg_q   <= seg_d;
         frame_q <= frame_d;
      end
   end

   assign oSel   = sel_q;
   assign oEna   = ena_q;
   assign oSeg   = seg_q;
   assign oFrame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl : directed + random checks of seg_scan_ctrl against a timeline model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;
   localparam int DIV   = 8;
   localparam int GUARD = 2;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [31:0] num;
   logic [7:0]  dp, blank;
   logic [2:0]  sel_a, sel_b;
   logic [1:0]  ena_a, ena_b;
   logic [7:0]  seg_a, seg_b;
   logic        frame_a, frame_b;

   int errors = 0;
   int checks = 0;

   int         t    [2];
   bit         run  [2];
   logic [7:0] snap [2];
   logic [13:0] expv [2];
   int         nd   [2];
   logic [6:0] tbl  [16];

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DIV(DIV), .GUARD(GUARD), .DIGITS(8)) u_a (
      .iClk(clk), .iRst(rst), .iEn(en), .iNum(num), .iDp(dp), .iBlank(blank),
      .oSel(sel_a), .oEna(ena_a), .oSeg(seg_a), .oFrame(frame_a));

   seg_scan_ctrl #(.DIV(DIV), .GUARD(GUARD), .DIGITS(3)) u_b (
      .iClk(clk), .iRst(rst), .iEn(en), .iNum(num), .iDp(dp), .iBlank(blank),
      .oSel(sel_b), .oEna(ena_b), .oSeg(seg_b), .oFrame(frame_b));

   function automatic logic [7:0] ref_seg(input int d);
      logic [3:0] nib;
      nib = num[4*d +: 4];
      return blank[d] ? 8'hFF : {~dp[d], tbl[nib]};
   endfunction

   // Expected outputs follow purely from time elapsed since scanning started.
   function automatic logic [13:0] model_out(input int k);
      int         s;
      logic [1:0] e;
      logic       f;
      if (!run[k]) return {3'd0, 2'b00, 8'hFF, 1'b0};
      s = (t[k] / DIV) % nd[k];
      e = ((t[k] % DIV) >= GUARD && !blank[s]) ? 2'b10 : 2'b00;
      f = (t[k] > 0) && (t[k] % (DIV * nd[k]) == 0);
      return {3'(s), e, snap[k], f};
   endfunction

   task automatic model_edge(input int k);
      if (rst || !en) begin
         run[k] = 1'b0;
      end else if (!run[k]) begin
         run[k]  = 1'b1;
         t[k]    = 0;
         snap[k] = ref_seg(0);
      end else begin
         t[k] = t[k] + 1;
         if (t[k] % DIV == 0) snap[k] = ref_seg((t[k] / DIV) % nd[k]);
      end
      expv[k] = model_out(k);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         run[k]  = 1'b0;
         expv[k] = {3'd0, 2'b00, 8'hFF, 1'b0};
      end
   endtask

   task automatic check_model(input int k);
      logic [13:0] obs;
      obs = (k == 0) ? {sel_a, ena_a, seg_a, frame_a} : {sel_b, ena_b, seg_b, frame_b};
      checks++;
      assert (obs === expv[k]) else begin
         errors++;
         $error("FAIL model_%0d observed=%h expected=%h t=%0d", k, obs, expv[k], t[k]);
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_model(0);
      check_model(1);
   endtask

   task automatic wait_pos(input int digit, input int pos);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (run[0] && (t[0] / DIV) % 8 == digit && t[0] % DIV == pos) begin
            hit = 1'b1;
            break;
         end
      end
      chk("wait_timeout", {15'd0, hit}, 16'd1);
   endtask

   initial begin
      int fa, fb;
      tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      nd[0] = 8;
      nd[1] = 3;
      model_reset();
      rst   = 1'b1;
      en    = 1'b1;
      num   = 32'h76543210;
      dp    = 8'h00;
      blank = 8'h00;

      // Reset held with enable high: idle outputs
      repeat (3) step();
      chk("rst_idle", {2'd0, sel_a, ena_a, seg_a, frame_a}, {2'd0, 3'd0, 2'b00, 8'hFF, 1'b0});
      rst = 1'b0;
      step();
      step();
      chk("guard_edge2", {14'd0, ena_a}, 16'h0000);
      step();
      chk("first_ena", {11'd0, sel_a, ena_a}, {11'd0, 3'd0, 2'b10});

      // Full scan; frame pulse counts over a window of 3 x 64 cycles
      fa = 0;
      fb = 0;
      for (int i = 0; i < 192; i++) begin
         step();
         fa += int'(frame_a);
         fb += int'(frame_b);
      end
      chk("frames_a", 16'(fa), 16'd3);
      chk("frames_b", 16'(fb), 16'd8);
      wait_pos(3, 2);
      chk("seg_digit3", {8'd0, seg_a}, 16'h00B0);

      // Blank digit 2, decimal point on digit 0
      blank = 8'h04;
      dp    = 8'h01;
      repeat (64) step();
      wait_pos(0, 3);
      chk("seg_dp0", {8'd0, seg_a}, 16'h0040);
      wait_pos(2, 5);
      chk("blank_ena", {14'd0, ena_a}, 16'h0000);

      // Mid-slot data change is deferred to the next visit
      blank = 8'h00;
      dp    = 8'h00;
      repeat (64) step();
      wait_pos(1, 4);
      num[7:4] = 4'hF;
      repeat (3) step();
      chk("midslot_hold", {8'd0, seg_a}, 16'h00F9);
      wait_pos(1, 0);
      chk("midslot_new", {8'd0, seg_a}, 16'h008E);

      // Stop mid-slot, then restart from digit 0 with a full guard
      wait_pos(5, 3);
      en = 1'b0;
      step();
      chk("stop_idle", {11'd0, sel_a, ena_a}, {11'd0, 3'd0, 2'b00});
      en = 1'b1;
      step();
      step();
      chk("restart_guard", {14'd0, ena_a}, 16'h0000);
      step();
      chk("restart_ena", {11'd0, sel_a, ena_a}, {11'd0, 3'd0, 2'b10});

      // Asynchronous reset mid-slot takes effect without a clock edge
      repeat (13) step();
      rst = 1'b1;
      #1;
      model_reset();
      check_model(0);
      check_model(1);
      chk("async_rst", {2'd0, sel_a, ena_a, seg_a, frame_a}, {2'd0, 3'd0, 2'b00, 8'hFF, 1'b0});
      step();
      rst = 1'b0;
      repeat (3) step();
      chk("post_rst_ena", {11'd0, sel_a, ena_a}, {11'd0, 3'd0, 2'b10});

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(15) == 0) num   = $urandom;
         if ($urandom_range(15) == 0) dp    = 8'($urandom);
         if ($urandom_range(15) == 0) blank = 8'($urandom) & 8'($urandom);
         en = ($urandom_range(39) != 0);
         if ($urandom_range(199) == 0) begin
            rst = 1'b1;
            #1;
            model_reset();
            check_model(0);
            check_model(1);
            step();
            rst = 1'b0;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
